// File: rtl/conv_mac_pipe.sv
// Pipelined K_SIZE x K_SIZE signed multiply-accumulate: product stage, registered adder tree.
// Optional build macro CONV_MAC_RELU_EN clamps negative results to zero at the output.
module conv_mac_pipe #(
  parameter int I_BIT_WIDTH = 8,
  parameter int O_BIT_WIDTH = 32,
  parameter int K_SIZE      = 3
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [I_BIT_WIDTH*K_SIZE*K_SIZE-1:0]   in,
  input  logic [I_BIT_WIDTH*K_SIZE*K_SIZE-1:0]   weights,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [O_BIT_WIDTH-1:0]                 conv_value
);

  localparam int N     = K_SIZE * K_SIZE;
  localparam int D     = $clog2(N);
  localparam int P_W   = 2 * I_BIT_WIDTH;
  localparam int ACC_W = P_W + D;

  // Number of live nodes at tree level l (level 0 holds the raw products).
  function automatic int level_cnt(input int l);
    return (N + (1 << l) - 1) >> l;
  endfunction

  logic signed [P_W-1:0]   prod [0:N-1];
  // Second dimension is padded to 2*N so the pair index 2*i+1 never leaves the array.
  logic signed [ACC_W-1:0] data [0:D][0:2*N-1];
  logic                    vld  [0:D];

  assign out_valid = vld[D];
  assign in_ready  = !out_valid || out_ready;

  always_comb begin
    for (int n = 0; n < N; n++) begin
      prod[n] = P_W'($signed(in[n*I_BIT_WIDTH +: I_BIT_WIDTH])) *
                P_W'($signed(weights[n*I_BIT_WIDTH +: I_BIT_WIDTH]));
    end
  end

  // NOTE: state uses non-blocking assignments so every stage samples the
  // previous stage's pre-edge value, which is what makes this a pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data array is cleared on reset so conv_value reads 0
      // immediately; this is an explicit requirement, not a default habit.
      for (int l = 0; l <= D; l++) begin
        vld[l] <= 1'b0;
        for (int i = 0; i < 2*N; i++) data[l][i] <= '0;
      end
    end else if (in_ready) begin
      vld[0] <= in_valid;
      for (int n = 0; n < N; n++) data[0][n] <= ACC_W'(prod[n]);
      for (int l = 1; l <= D; l++) begin
        vld[l] <= vld[l-1];
        for (int i = 0; i < N; i++) begin
          if (i < level_cnt(l)) begin
            if (2*i + 1 < level_cnt(l-1))
              data[l][i] <= data[l-1][2*i] + data[l-1][2*i+1];
            else
              data[l][i] <= data[l-1][2*i];
          end
        end
      end
    end
  end

  logic signed [ACC_W-1:0]       acc;
  logic signed [O_BIT_WIDTH-1:0] sat;

  assign acc = data[D][0];

  generate
    if (O_BIT_WIDTH >= ACC_W) begin : g_extend
      assign sat = O_BIT_WIDTH'(acc);
    end else begin : g_saturate
      localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'({1'b0, {(O_BIT_WIDTH-1){1'b1}}});
      localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;
      always_comb begin
        if (acc > MAX_V)      sat = MAX_V[O_BIT_WIDTH-1:0];
        else if (acc < MIN_V) sat = MIN_V[O_BIT_WIDTH-1:0];
        else                  sat = acc[O_BIT_WIDTH-1:0];
      end
    end
  endgenerate

`ifdef CONV_MAC_RELU_EN
  assign conv_value = sat[O_BIT_WIDTH-1] ? '0 : sat;
`else
  assign conv_value = sat;
`endif

endmodule

// File: tb/tb_conv_mac_pipe.sv
// Directed bench for conv_mac_pipe: default, 16-bit saturating and K_SIZE=1 instances.
module tb_conv_mac_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready;
  logic [71:0] win, wts;
  logic        in_ready, out_valid, in_ready16, out_valid16;
  logic [31:0] conv_value;
  logic [15:0] conv16;
  logic        v1_valid, v1_ready, v1_ovalid, v1_oready;
  logic [7:0]  v1_in, v1_w;
  logic [31:0] v1_cv;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  conv_mac_pipe u_main (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in(win), .weights(wts), .out_valid(out_valid), .out_ready(out_ready),
    .conv_value(conv_value)
  );

  conv_mac_pipe #(.O_BIT_WIDTH(16)) u_o16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
    .in(win), .weights(wts), .out_valid(out_valid16), .out_ready(out_ready),
    .conv_value(conv16)
  );

  conv_mac_pipe #(.K_SIZE(1)) u_k1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1_valid), .in_ready(v1_ready),
    .in(v1_in), .weights(v1_w), .out_valid(v1_ovalid), .out_ready(v1_oready),
    .conv_value(v1_cv)
  );

  typedef struct {
    string name;
    int    a0, as, b0, bs;   // element n = base + step*n
    int    exp32, exp16;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [71:0] mk(input int base, input int step);
    logic [71:0] v;
    for (int n = 0; n < 9; n++) v[n*8 +: 8] = 8'(base + step*n);
    return v;
  endfunction

  function automatic longint relu(input longint x);
`ifdef CONV_MAC_RELU_EN
    return (x < 0) ? 0 : x;
`else
    return x;
`endif
  endfunction

  initial begin
    int lat, sent, got, stalls, extra;
    logic [31:0] held;
    logic acc;

    vecs[0] = '{"max_pos",   127,  0,  127, 0, 145161,  32767};
    vecs[1] = '{"max_neg",  -128,  0,  127, 0, -146304, -32768};
    vecs[2] = '{"ramp",        1,  1,    1, 0,     45,     45};
    vecs[3] = '{"squares",    -4,  1,   -4, 1,     60,     60};
    vecs[4] = '{"zero_w",      5,  0,    0, 0,      0,      0};
    vecs[5] = '{"neg_neg",    -1,  0, -128, 0,   1152,   1152};
    vecs[6] = '{"ramp10",      0, 10,    2, 0,    720,    720};
    vecs[7] = '{"min_min",  -128,  0, -128, 0, 147456,  32767};
    vecs[8] = '{"mixed",      10, -3,    1, 1,   -270,   -270};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; win = '0; wts = '0;
    v1_valid = 1'b0; v1_oready = 1'b1; v1_in = '0; v1_w = '0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_conv_value", conv_value, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_k1_out_valid", v1_ovalid, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    for (int v = 0; v < 9; v++) begin
      @(negedge clk);
      win = mk(vecs[v].a0, vecs[v].as);
      wts = mk(vecs[v].b0, vecs[v].bs);
      in_valid = 1'b1;
      #1 check({vecs[v].name, "_in_ready"}, in_ready, 1);
      @(posedge clk);
      lat = 1;
      #1 in_valid = 1'b0;
      while (!out_valid && lat < 20) begin
        @(posedge clk);
        #1 lat++;
      end
      check({vecs[v].name, "_latency"}, lat, 5);
      check({vecs[v].name, "_o32"}, $signed(conv_value), relu(vecs[v].exp32));
      check({vecs[v].name, "_o16"}, $signed(conv16), relu(vecs[v].exp16));
      @(posedge clk);
      #1 check({vecs[v].name, "_drained"}, out_valid, 0);
    end

    // K_SIZE=1: single product, one-cycle latency.
    @(negedge clk);
    v1_in = 8'(-5); v1_w = 8'd7; v1_valid = 1'b1;
    @(posedge clk);
    #1 v1_valid = 1'b0;
    check("k1_valid", v1_ovalid, 1);
    check("k1_value", $signed(v1_cv), relu(-35));
    @(negedge clk);
    v1_in = 8'd127; v1_w = 8'(-128); v1_valid = 1'b1;
    @(posedge clk);
    #1 v1_valid = 1'b0;
    check("k1_value2", $signed(v1_cv), relu(-16256));
    @(posedge clk);
    #1 check("k1_drained", v1_ovalid, 0);

    // Stream 10 windows with a 3-cycle downstream stall.
    sent = 0; got = 0; stalls = 0; held = '0;
    for (int c = 0; c < 80 && got < 10; c++) begin
      @(negedge clk);
      out_ready = !(c >= 8 && c <= 10);
      if (sent < 10) begin
        in_valid = 1'b1; win = mk(sent + 1, 0); wts = mk(1, 0);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && out_ready) begin
        check("stream_data", $signed(conv_value), relu(9 * (got + 1)));
        got++;
      end
      if (out_valid && !out_ready) begin
        if (!in_ready) stalls++;
        if (c > 8) check("stall_hold", conv_value, held);
        held = conv_value;
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) sent++;
    end
    check("stream_sent", sent, 10);
    check("stream_count", got, 10);
    check("stall_cycles", stalls, 3);
    @(negedge clk) in_valid = 1'b0; out_ready = 1'b1;
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    check("stream_no_extra", extra, 0);

    // Reset with three windows in flight.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1; win = mk(k + 2, 0); wts = mk(3, 0);
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_conv_value", conv_value, 0);
    check("midrst_conv16", conv16, 0);
    check("midrst_in_ready", in_ready, 1);
    @(negedge clk) rst_n = 1'b1;
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    check("midrst_no_output", extra, 0);

    // Recovery after reset.
    @(negedge clk);
    win = mk(2, 0); wts = mk(-3, 0); in_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    #1 in_valid = 1'b0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    check("recover_latency", lat, 5);
    check("recover_value", $signed(conv_value), relu(-54));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/conv_mac_pipe.md
CONV_MAC_PIPE -- requirements
Module: conv_mac_pipe

Interface
REQ-001 SHALL have parameter I_BIT_WIDTH, default 8: signed width of each pixel and weight element.
REQ-002 SHALL have parameter O_BIT_WIDTH, default 32: signed width of conv_value.
REQ-003 SHALL have parameter K_SIZE, default 3: kernel edge; window holds K_SIZE*K_SIZE elements; any value >=1 legal.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port in_valid  input  1  window/weights valid.
REQ-007 SHALL have port in_ready  output  1  block accepts a window this cycle.
REQ-008 SHALL have port in  input  I_BIT_WIDTH*K_SIZE*K_SIZE  packed signed window; element n at bits [I_BIT_WIDTH*(n+1)-1 : I_BIT_WIDTH*n], n = K_SIZE*row+col.
REQ-009 SHALL have port weights  input  I_BIT_WIDTH*K_SIZE*K_SIZE  packed signed kernel, same packing as in.
REQ-010 SHALL have port out_valid  output  1  conv_value holds a result.
REQ-011 SHALL have port out_ready  input  1  downstream consumes result.
REQ-012 SHALL have port conv_value  output  O_BIT_WIDTH  signed sum of element-wise products.

Function
REQ-013 SHALL transfer an input when in_valid && in_ready on a rising clk edge; an output when out_valid && out_ready.
REQ-014 SHALL compute in_ready = !out_valid || out_ready (combinational); all pipeline stages advance together when in_ready is 1, hold when 0.
REQ-015 SHALL register K_SIZE*K_SIZE signed products of full width 2*I_BIT_WIDTH in stage 1.
REQ-016 SHALL reduce products with a registered binary adder tree of D = ceil(log2(K_SIZE*K_SIZE)) levels; an odd node at a level passes through unchanged to the next level.
REQ-017 SHALL accumulate at ACC_W = 2*I_BIT_WIDTH + D bits, so no internal overflow occurs.
REQ-018 SHALL produce conv_value D+1 cycles after acceptance with out_ready held 1 (K_SIZE=3: 5 cycles; K_SIZE=1: 1 cycle).
REQ-019 SHALL carry a valid bit per stage; bubbles (in_valid=0 while in_ready=1) propagate as invalid stages and never raise out_valid.
REQ-020 SHALL sign-extend the ACC_W result to O_BIT_WIDTH when O_BIT_WIDTH >= ACC_W, else saturate to [-2^(O_BIT_WIDTH-1), 2^(O_BIT_WIDTH-1)-1].
REQ-021 SHALL hold out_valid and conv_value stable while out_valid && !out_ready.
REQ-022 SHALL accept a new input in the same cycle an output is consumed (full throughput, one result per cycle).
REQ-023 SHALL ignore in and weights values when in_valid is 0.

Reset
REQ-024 SHALL on rst_n low immediately clear all stage valid bits, out_valid=0, conv_value=0, all pipeline data registers=0.
REQ-025 SHALL discard in-flight windows when reset asserts mid-operation; no result emerges after release.
REQ-026 SHALL drive in_ready=1 during and after reset (out_valid=0).

Configuration
REQ-027 SHALL, with macro CONV_MAC_RELU_EN defined, clamp a negative final result to 0 after saturation/extension, in the output stage with no added latency.
REQ-028 SHALL, without CONV_MAC_RELU_EN, output signed results unmodified; latency and handshake identical in both builds.

Verification (K_SIZE=3, I_BIT_WIDTH=8, O_BIT_WIDTH=32 unless stated)
REQ-029 All in=127, weights=127, out_ready=1 -> out_valid 5 cycles later, conv_value=145161.
REQ-030 All in=-128, weights=127 -> conv_value=-146304; with CONV_MAC_RELU_EN -> 0.
REQ-031 O_BIT_WIDTH=16, all in=127, weights=127 -> 32767; all in=-128, weights=127 -> -32768.
REQ-032 Stream 10 windows back-to-back, out_ready low 3 cycles mid-stream -> in_ready low those cycles, conv_value held, all 10 results in order, none lost/duplicated.
REQ-033 Accept 3 windows, assert rst_n low 1 cycle -> out_valid=0, conv_value=0 immediately; no output afterwards until new input.
REQ-034 K_SIZE=1, in=-5, weights=7 -> conv_value=-35 after 1 cycle.
